skolem_check_sequencer: RTL and testbench
=========================================

Name: skolem_check_sequencer

Overview:
- Exhaustive-check controller for one synthesized Skolem function block, e.g. the 4-input/9-output adder Skolem formula.
- Enumerates every universal-input assignment, drives it into the Skolem function, waits for settling, then samples the outputs and an external combinational specification checker.
- Reports pass, or the first counterexample (inputs and outputs).
- Sits between the Skolem block, the spec checker and the bench/CSR host that issues start.

Parameters:
- NUM_X, 4, number of universal inputs driven into the Skolem block.
- NUM_Y, 9, number of Skolem outputs sampled.
- SETTLE, 1, cycles x_out is held stable before sampling; legal range ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled only in IDLE; begins a scan.
- abort  in  1  cancels a running scan.
- x_out  out  NUM_X  assignment driven to the Skolem block inputs.
- y_in  in  NUM_Y  Skolem block outputs.
- spec_ok  in  1  checker verdict for (x_out, y_in).
- busy  out  1  high from start acceptance until DONE is left.
- done  out  1  one-cycle pulse at scan completion.
- pass  out  1  result of the last completed scan.
- cex_valid  out  1  cex_x/cex_y hold a counterexample.
- cex_x  out  NUM_X  failing assignment.
- cex_y  out  NUM_Y  y_in captured with cex_x.
- fail_count  out  NUM_X+1  present only with the macro.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; x_out, cex_x, cex_y, fail_count = 0; busy, done, pass, cex_valid = 0. A scan in progress is discarded and no done is issued.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE, start=1 and abort=0: x_out←0, settle_cnt←0, pass←0, cex_valid←0, go to WAIT. If abort=1, start is ignored.
- WAIT: if settle_cnt==SETTLE-1, go to CHECK; else settle_cnt++. x_out is stable throughout.
- CHECK: sample spec_ok and y_in.
  - spec_ok=0: cex_x←x_out, cex_y←y_in, cex_valid←1, pass←0, go to DONE.
  - spec_ok=1 and x_out is all-ones: pass←1, go to DONE.
  - Otherwise: x_out←x_out+1, settle_cnt←0, go to WAIT.
- DONE: done=1 for this cycle only, then go to IDLE. busy=1 in WAIT, CHECK and DONE.
- Latency:
  - Each vector costs SETTLE+1 cycles.
  - A full passing scan asserts done in the cycle starting 2^NUM_X·(SETTLE+1)+1 edges after the start-accepting edge.
  - A scan failing at vector k asserts done at (k+1)·(SETTLE+1)+1.
- abort=1 in WAIT or CHECK: go to IDLE next edge; no done, pass=0, cex_valid=0, x_out holds its value. abort in DONE is ignored.
- start while busy is ignored, with no queueing.
- pass, cex_* and fail_count hold until the next accepted start.
- x_out never wraps: the scan terminates at all-ones.

Optional Feature:
- SKOLEM_CHECK_FULL_SCAN_EN defined:
  - Failures do not stop the scan; every vector is checked.
  - cex_x/cex_y keep the first failure only.
  - fail_count increments per failing vector, saturating at 2^NUM_X.
  - At DONE, pass = (fail_count==0).
  - Latency is always the full-scan value.
- Undefined: stop-at-first-failure as above; the fail_count port and its counter are absent.

Decomposition:
- Shared package skolem_check_pkg:
  - state enum type.
  - Default width localparams.
  - Function computing the scan cycle count, for use by the bench.
- Sub-module skolem_settle_timer: settle_cnt load/terminal-count, parameterized by SETTLE.
- Everything else lives in the top FSM.

Test Plan:
- Always-ok checker, NUM_X=4, SETTLE=1, start at edge 0 → x_out steps 0..15, done at cycle 33, pass=1, cex_valid=0.
- Checker fails only at x=5, y_in=9'h0A3 → done at cycle 13, pass=0, cex_x=5, cex_y=9'h0A3, cex_valid=1.
- SETTLE=3, fail at x=0 → done at cycle 5; x_out stays 0 for 4 cycles.
- abort at cycle 10 of a passing scan → busy drops at cycle 11, no done pulse; a new start then restarts from x_out=0. start pulsed at cycle 5 of a scan has no effect.
- rst_n low at cycle 7, asynchronous between edges → all outputs 0 immediately; on release the FSM is in IDLE.
- With SKOLEM_CHECK_FULL_SCAN_EN, failures at x=3 and x=9 → done at cycle 33, fail_count=2, cex_x=3, pass=0.

Source files
------------

// File: rtl/skolem_check_pkg.sv
// Shared types and defaults for the Skolem exhaustive-check sequencer.
// Holds the FSM state enum, default widths and a scan-length helper.
package skolem_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int DEF_NUM_X  = 4;
  localparam int DEF_NUM_Y  = 9;
  localparam int DEF_SETTLE = 1;

  // Cycle, counted from 1 at the start-accepting edge, in which done
  // is high after `vectors` assignments have been checked.
  function automatic int scan_cycles(input int vectors,
                                     input int settle);
    return vectors * (settle + 1) + 1;
  endfunction

endpackage

// File: rtl/skolem_settle_timer.sv
// Settle counter: cleared on load_i, counts while en_i, tc_o flags SETTLE-1.
// Ports: clk, rst_n, load_i, en_i in; tc_o out.
module skolem_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] TC  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;

  assign tc_o = (cnt_q == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/skolem_check_sequencer.sv
// Enumerates all x assignments into a Skolem block and checks each one.
// Ports: clk, rst_n, start, abort, y_in, spec_ok in; x_out, busy, done,
// pass, cex_valid, cex_x, cex_y out; fail_count with
// SKOLEM_CHECK_FULL_SCAN_EN (scan continues past failures, counts them).
module skolem_check_sequencer
  import skolem_check_pkg::*;
#(
  parameter int NUM_X  = DEF_NUM_X,
  parameter int NUM_Y  = DEF_NUM_Y,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [NUM_X-1:0] x_out,
  input  logic [NUM_Y-1:0] y_in,
  input  logic             spec_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             cex_valid,
  output logic [NUM_X-1:0] cex_x,
  output logic [NUM_Y-1:0] cex_y
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  ,
  output logic [NUM_X:0]   fail_count
`endif
);

  localparam logic [NUM_X-1:0] X_ONE = NUM_X'(1);

  state_e           state_q, state_d;
  logic [NUM_X-1:0] x_q, x_d;
  logic [NUM_X-1:0] cx_q, cx_d;
  logic [NUM_Y-1:0] cy_q, cy_d;
  logic             pass_q, pass_d;
  logic             cexv_q, cexv_d;
  logic             tmr_load;
  logic             tmr_tc;
  logic             last;

`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  localparam logic [NUM_X:0] FC_MAX = {1'b1, {NUM_X{1'b0}}};
  localparam logic [NUM_X:0] FC_ONE = (NUM_X+1)'(1);
  logic [NUM_X:0] fc_q, fc_d;
  assign fail_count = fc_q;
`endif

  assign last = &x_q;

  skolem_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .en_i   (state_q == S_WAIT),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    pass_d   = pass_q;
    cexv_d   = cexv_q;
    tmr_load = 1'b0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    fc_d     = fc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          x_d      = '0;
          tmr_load = 1'b1;
          pass_d   = 1'b0;
          cexv_d   = 1'b0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
          fc_d     = '0;
`endif
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          pass_d  = 1'b0;
          cexv_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tmr_tc) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          cexv_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
          if (!spec_ok) begin
            // Only the first failure is kept as the counterexample.
            if (!cexv_q) begin
              cx_d   = x_q;
              cy_d   = y_in;
              cexv_d = 1'b1;
            end
            if (fc_q != FC_MAX) begin
              fc_d = fc_q + FC_ONE;
            end
          end
          if (last) begin
            pass_d  = (fc_d == '0);
            state_d = S_DONE;
          end else begin
            x_d      = x_q + X_ONE;
            tmr_load = 1'b1;
            state_d  = S_WAIT;
          end
`else
          if (!spec_ok) begin
            cx_d    = x_q;
            cy_d    = y_in;
            cexv_d  = 1'b1;
            pass_d  = 1'b0;
            state_d = S_DONE;
          end else if (last) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x_d      = x_q + X_ONE;
            tmr_load = 1'b1;
            state_d  = S_WAIT;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      pass_q  <= 1'b0;
      cexv_q  <= 1'b0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
      fc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      pass_q  <= pass_d;
      cexv_q  <= cexv_d;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
      fc_q    <= fc_d;
`endif
    end
  end

  assign x_out     = x_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign cex_valid = cexv_q;
  assign cex_x     = cx_q;
  assign cex_y     = cy_q;

endmodule

// File: tb/tb_skolem_check_sequencer.sv
// Self-checking bench for skolem_check_sequencer (SETTLE=1 and SETTLE=3).
// Also covers the SKOLEM_CHECK_FULL_SCAN_EN build when that macro is set.
module tb_skolem_check_sequencer;
  import skolem_check_pkg::*;

`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  typedef struct {
    logic [15:0] mask;
    int          done_cyc;
    logic        pass;
    logic        cexv;
    logic [3:0]  cx;
    logic [8:0]  cy;
    int          nfail;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, start3;
  logic [15:0] mask;
  logic [3:0]  x, x3, cx, cx3;
  logic [8:0]  y, y3, cy, cy3;
  logic        ok, ok3;
  logic        busy, done, pass, cexv;
  logic        busy3, done3, pass3, cexv3;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  logic [4:0]  fc, fc3;
`endif

  // Skolem block stand-in: y depends on x; checker fails where mask is set.
  assign y   = {x, 5'h03};
  assign ok  = !mask[x];
  assign y3  = {x3, 5'h03};
  assign ok3 = 1'b0;

  skolem_check_sequencer #(
    .NUM_X(4), .NUM_Y(9), .SETTLE(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_out(x), .y_in(y), .spec_ok(ok), .busy(busy), .done(done),
    .pass(pass), .cex_valid(cexv), .cex_x(cx), .cex_y(cy)
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    , .fail_count(fc)
`endif
  );

  skolem_check_sequencer #(
    .NUM_X(4), .NUM_Y(9), .SETTLE(3)
  ) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
    .x_out(x3), .y_in(y3), .spec_ok(ok3), .busy(busy3), .done(done3),
    .pass(pass3), .cex_valid(cexv3), .cex_x(cx3), .cex_y(cy3)
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    , .fail_count(fc3)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tab[5];

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic run_case(input vec_t v);
    vec_t e;
    int   c;
    bit   xerr;
    mask = v.mask;
    sb.push_back(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    xerr = 1'b0;
    while (!done && c < 200) begin
      if (x !== 4'((c - 1) / 2) || busy !== 1'b1) xerr = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("xstep", {31'd0, xerr}, 32'd0);
    chk("done_seen", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk("done_cyc", c, e.done_cyc);
    chk("pass", {31'd0, pass}, {31'd0, e.pass});
    chk("cex_valid", {31'd0, cexv}, {31'd0, e.cexv});
    if (e.cexv) begin
      chk("cex_x", {28'd0, cx}, {28'd0, e.cx});
      chk("cex_y", {23'd0, cy}, {23'd0, e.cy});
    end
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    chk("fail_count", {27'd0, fc}, e.nfail);
`endif
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  c;
    bit  xerr;
    bit  seen;

    tab[0] = '{16'h0000, 33, 1'b1, 1'b0, 4'h0, 9'h000, 0};
    tab[1] = '{16'h0020, FS ? 33 : 13, 1'b0, 1'b1, 4'h5, 9'h0A3, 1};
    tab[2] = '{16'h0208, FS ? 33 : 9, 1'b0, 1'b1, 4'h3, 9'h063, 2};
    tab[3] = '{16'h8000, 33, 1'b0, 1'b1, 4'hF, 9'h1E3, 1};
    tab[4] = '{16'hFFFF, FS ? 33 : 3, 1'b0, 1'b1, 4'h0, 9'h003, 16};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    mask = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_cexv", {31'd0, cexv}, 32'd0);
    chk("rst_x", {28'd0, x}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_case(tab[i]);

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_blocks_start", {31'd0, busy}, 32'd0);

    // start pulse mid-scan ignored, abort at cycle 10
    mask = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    xerr = 1'b0;
    while (c <= 10) begin
      if (x !== 4'((c - 1) / 2)) xerr = 1'b1;
      start = (c == 5);
      abort = (c == 10);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; abort = 1'b0;
    chk("abort_xstep", {31'd0, xerr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_x_hold", {28'd0, x}, 32'd4);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    chk("abort_cexv", {31'd0, cexv}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    run_case(tab[0]);

    // asynchronous reset mid-scan at cycle 7
    mask = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_x", {28'd0, x}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", {31'd0, busy}, 32'd0);
    run_case(tab[1]);

    // SETTLE=3, checker fails at x=0
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    c = 1;
    xerr = 1'b0;
    while (!done3 && c < 200) begin
      if (c <= 4 && (x3 !== 4'h0 || busy3 !== 1'b1)) xerr = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("s3_x_hold", {31'd0, xerr}, 32'd0);
    chk("s3_done_cyc", c, scan_cycles(FS ? 16 : 1, 3));
    chk("s3_pass", {31'd0, pass3}, 32'd0);
    chk("s3_cexv", {31'd0, cexv3}, 32'd1);
    chk("s3_cex_x", {28'd0, cx3}, 32'd0);
    chk("s3_cex_y", {23'd0, cy3}, 32'h003);
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    chk("s3_fail_count", {27'd0, fc3}, 32'd16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
